// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO for the MIPS EX stage.
// Optional abort port enabled by defining MDU_CANCEL_EN.
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            mthi,
    input  logic            mtlo,
`ifdef MDU_CANCEL_EN
    input  logic            cancel,
`endif
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   w_hi, w_lo, opb, a_raw;
    logic              is_div, neg_q, neg_r, b_zero;
    logic              kill;

`ifdef MDU_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    assign busy = (state_q != S_IDLE);

    // Operand conditioning: signed ops work on magnitudes, signs fixed up in FIX.
    logic            sgn;
    logic [XLEN-1:0] a_abs, b_abs;
    assign sgn   = ~op[0];
    assign a_abs = (sgn && A[XLEN-1]) ? (~A + 1'b1) : A;
    assign b_abs = (sgn && B[XLEN-1]) ? (~B + 1'b1) : B;

    // One shift-add step: w_hi accumulates, w_lo holds the remaining multiplier bits.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});

    // One restoring-divide step: w_hi is the partial remainder, w_lo dividend/quotient.
    logic [XLEN:0] div_r, div_diff;
    assign div_r    = {w_hi, w_lo[XLEN-1]};
    assign div_diff = div_r - {1'b0, opb};

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix;
    assign prod     = {w_hi, w_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign q_fix    = neg_q ? (~w_lo + 1'b1) : w_lo;
    assign r_fix    = neg_r ? (~w_hi + 1'b1) : w_hi;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (start) state_d = op[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (count == CW'(XLEN-1)) state_d = S_FIX;
            S_FIX:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        if (kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count       <= '0;
            w_hi        <= '0;
            w_lo        <= '0;
            opb         <= '0;
            a_raw       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count  <= '0;
                        w_hi   <= '0;
                        w_lo   <= op[1] ? a_abs : b_abs;
                        opb    <= op[1] ? b_abs : a_abs;
                        a_raw  <= A;
                        is_div <= op[1];
                        neg_q  <= sgn & (A[XLEN-1] ^ B[XLEN-1]);
                        neg_r  <= sgn & A[XLEN-1];
                        b_zero <= (B == '0);
                    end else begin
                        if (mthi) HI <= A;
                        if (mtlo) LO <= A;
                    end
                end
                S_MUL: begin
                    w_hi  <= mul_sum[XLEN:1];
                    w_lo  <= {mul_sum[0], w_lo[XLEN-1:1]};
                    count <= count + 1'b1;
                end
                S_DIV: begin
                    w_hi  <= div_diff[XLEN] ? div_r[XLEN-1:0] : div_diff[XLEN-1:0];
                    w_lo  <= {w_lo[XLEN-2:0], ~div_diff[XLEN]};
                    count <= count + 1'b1;
                end
                S_FIX: begin
                    if (!kill) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            HI <= prod_fix[2*XLEN-1:XLEN];
                            LO <= prod_fix[XLEN-1:0];
                        end else if (b_zero) begin
                            HI          <= a_raw;
                            LO          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            HI <= r_fix;
                            LO <= q_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded bench for mult_div_unit: vector table, random ops vs. a behavioural model, corner sequences.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] A, B, HI, LO;
    logic        busy, done, div_by_zero;
`ifdef MDU_CANCEL_EN
    logic        cancel = 1'b0;
`endif

    mult_div_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] op; logic [31:0] a, b, hi, lo; logic dbz; } vec_t;
    typedef struct { logic [31:0] hi, lo; logic dbz; } exp_t;

    exp_t sbq[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, done_cnt = 0, busy_cnt = 0, n_push = 0;
    int   t_issue, b_issue;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        e.dbz = 1'b0;
        case (o)
            2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin up = {32'h0, a} * {32'h0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Called on a negedge; start is held across exactly one rising edge.
    task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b, bit push, exp_t e);
        op = o; A = a; B = b; start = 1'b1;
        t_issue = cyc;
        b_issue = busy_cnt;
        if (push) begin sbq.push_back(e); n_push++; end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns on the negedge where done is visible, so a follow-on issue is back-to-back.
    task automatic wait_done(string nm);
        exp_t e;
        while (!done && (cyc - t_issue) < 100) @(negedge clk);
        if (!done) begin
            chk({nm, "_timeout"}, 32'h0, 32'h1);
        end else if (sbq.size() == 0) begin
            chk({nm, "_unexpected_done"}, 32'h1, 32'h0);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_hi"}, HI, e.hi);
            chk({nm, "_lo"}, LO, e.lo);
            chk({nm, "_dbz"}, {31'h0, div_by_zero}, {31'h0, e.dbz});
            chk({nm, "_latency"}, cyc - t_issue - 1, 33);
            chk({nm, "_busy_cycles"}, busy_cnt - b_issue, 33);
        end
    endtask

    vec_t tbl[9];
    exp_t ex;
    logic [31:0] hsave, ra, rb;
    logic [1:0]  ro;
    int d0;

    initial begin
        tbl[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[2] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5] = '{2'b11, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        tbl[6] = '{2'b10, 32'hFFFFFFF7, 32'h0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1};
        tbl[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_flags", {29'h0, busy, done, div_by_zero}, 32'h0);

        // Table vectors, each issued in the done cycle of the previous one.
        for (int i = 0; i < 9; i++) begin
            ex = '{tbl[i].hi, tbl[i].lo, tbl[i].dbz};
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, ex);
            wait_done($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            issue(ro, ra, rb, 1'b1, model(ro, ra, rb));
            wait_done($sformatf("rnd%0d", i));
        end
        @(negedge clk);

        // MTHI / MTLO / both
        A = 32'h55; mthi = 1'b1; @(negedge clk); mthi = 1'b0;
        chk("mthi_hi", HI, 32'h55);
        chk("mthi_no_done", {31'h0, done}, 32'h0);
        A = 32'h66; mthi = 1'b1; mtlo = 1'b1; @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth_hi", HI, 32'h66);
        chk("mtboth_lo", LO, 32'h66);

        // start beats mtlo in the same cycle
        mtlo = 1'b1;
        issue(2'b01, 32'h77, 32'h1, 1'b1, '{32'h0, 32'h77, 1'b0});
        mtlo = 1'b0;
        chk("start_wins_lo", LO, 32'h66);
        wait_done("start_wins");
        @(negedge clk);

        // start and mthi during a busy DIVU are ignored
        hsave = HI;
        d0 = done_cnt;
        issue(2'b11, 32'd100, 32'd7, 1'b1, '{32'd2, 32'd14, 1'b0});
        repeat (9) @(negedge clk);
        op = 2'b00; A = 32'd2; B = 32'd3; start = 1'b1; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("busy_mthi_ignored", HI, hsave);
        wait_done("busy_ignore");
        repeat (45) @(negedge clk);
        chk("busy_ignore_one_done", done_cnt - d0, 1);

        // Reset in the middle of a MULT clears HI/LO and suppresses done
        A = 32'h55; mthi = 1'b1; @(negedge clk); mthi = 1'b0;
        issue(2'b00, 32'd9, 32'd9, 1'b0, '{32'h0, 32'h0, 1'b0});
        repeat (19) @(negedge clk);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("midrst_hi", HI, 32'h0);
        chk("midrst_lo", LO, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);

`ifdef MDU_CANCEL_EN
        A = 32'hAA; mtlo = 1'b1; @(negedge clk); mtlo = 1'b0;
        hsave = HI;
        issue(2'b00, 32'd2, 32'd3, 1'b0, '{32'h0, 32'h0, 1'b0});
        repeat (4) @(negedge clk);
        cancel = 1'b1; @(negedge clk); cancel = 1'b0;
        chk("cancel_busy", {31'h0, busy}, 32'h0);
        chk("cancel_lo", LO, 32'hAA);
        chk("cancel_hi", HI, hsave);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("cancel_no_done", done_cnt - d0, 0);
`endif

        chk("done_total", done_cnt, n_push);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
